// File: rtl/vga_byte_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_byte_tx_if
// Description : Pixel-word valid/ready handshake into the byte-wide VGA
//               transmitter. The master drives words; the slave (transmitter)
//               returns o_ready.
// Revision    : 1.0  initial release
// ============================================================================
interface vga_byte_tx_if #(
   parameter int PixelBitWidth = 16
);
   logic [PixelBitWidth-1:0] i_data;
   logic                     i_valid;
   logic                     o_ready;

   modport master (output i_data, output i_valid, input o_ready);
   modport slave  (input i_data, input i_valid, output o_ready);
endinterface
`default_nettype wire

// File: rtl/vga_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_byte_tx
// Description : Accepts whole pixels through a one-word hold register and
//               serialises them LSB-byte first onto an 8-bit lane, framed by
//               v_sync (frame) and h_sync (active line bytes).
//               Optional macro TX_TEST_PATTERN_EN adds i_pattern_sel, which
//               replaces handshake pixels with a pixel-index ramp.
// Revision    : 1.0  initial release
// ============================================================================
module vga_byte_tx #(
   parameter int PixelBitWidth = 16,
   parameter int H_PIXELS      = 640,
   parameter int H_BLANK       = 144,
   parameter int V_LINES       = 480,
   parameter int VSYNC_CYCLES  = 800,
   parameter int V_BACK_CYCLES = 800
) (
   input  wire logic        p_clk,
   input  wire logic        RST,
   input  wire logic        i_enable,
`ifdef TX_TEST_PATTERN_EN
   input  wire logic        i_pattern_sel,
`endif
   vga_byte_tx_if.slave     pix_if,
   output logic [7:0]       o_data,
   output logic             h_sync,
   output logic             v_sync,
   output logic             o_frame_start,
   output logic             o_underflow
);

   localparam int BYTES     = PixelBitWidth / 8;
   localparam int BCW       = (BYTES > 1)    ? $clog2(BYTES)    : 1;
   localparam int PCW       = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int LCW       = (V_LINES > 1)  ? $clog2(V_LINES)  : 1;
   localparam int BLANK_M1  = (H_BLANK > VSYNC_CYCLES) ? H_BLANK : VSYNC_CYCLES;
   localparam int BLANK_MAX = (BLANK_M1 > V_BACK_CYCLES) ? BLANK_M1 : V_BACK_CYCLES;
   localparam int KCW       = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

   localparam logic [BCW-1:0] BYTE_LAST   = BCW'(BYTES - 1);
   localparam logic [PCW-1:0] PIX_LAST    = PCW'(H_PIXELS - 1);
   localparam logic [LCW-1:0] LINE_LAST   = LCW'(V_LINES - 1);
   localparam logic [KCW-1:0] HBLANK_LAST = KCW'(H_BLANK - 1);
   localparam logic [KCW-1:0] VSYNC_LAST  = KCW'(VSYNC_CYCLES - 1);
   localparam logic [KCW-1:0] VBACK_LAST  = KCW'(V_BACK_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_VSYNC  = 3'd1;
   localparam logic [2:0] S_VBACK  = 3'd2;
   localparam logic [2:0] S_ACTIVE = 3'd3;
   localparam logic [2:0] S_HBLANK = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [BCW-1:0]           byte_q, byte_d;
   logic [PCW-1:0]           pix_q, pix_d;
   logic [LCW-1:0]           line_q, line_d;
   logic [KCW-1:0]           blank_q, blank_d;

   logic [PixelBitWidth-1:0] hold_q;
   logic                     hold_full_q;
   logic [PixelBitWidth-1:0] shift_q;
   logic [7:0]               data_q;
   logic                     h_sync_q, v_sync_q, frame_start_q, underflow_q;

   logic                     w_slot_start;
   logic                     w_consume;
   logic                     w_accept;
   logic                     w_pattern;
   logic [PixelBitWidth-1:0] w_pattern_word;
   logic [PixelBitWidth-1:0] w_pix_word;

`ifdef TX_TEST_PATTERN_EN
   logic [31:0] w_pix_idx32;
   assign w_pattern      = i_pattern_sel;
   assign w_pix_idx32    = 32'(pix_d);
   assign w_pattern_word = {BYTES{w_pix_idx32[7:0]}};
`else
   assign w_pattern      = 1'b0;
   assign w_pattern_word = '0;
`endif

   // A new pixel slot begins next cycle: derived purely from registered state,
   // so o_ready never depends on i_valid or i_enable.
   assign w_slot_start = ((state_q == S_VBACK)  && (blank_q == VBACK_LAST)) ||
                         ((state_q == S_HBLANK) && (blank_q == HBLANK_LAST) && (line_q != LINE_LAST)) ||
                         ((state_q == S_ACTIVE) && (byte_q == BYTE_LAST) && (pix_q != PIX_LAST));

   assign w_consume     = w_slot_start && hold_full_q && !w_pattern;
   assign pix_if.o_ready = !w_pattern && (!hold_full_q || w_consume);
   assign w_accept      = pix_if.i_valid && pix_if.o_ready;
   assign w_pix_word    = w_pattern   ? w_pattern_word :
                          hold_full_q ? hold_q         : '0;

   // Frame/line sequencing and counters; every counter returns to 0 on exit.
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      pix_d   = pix_q;
      line_d  = line_q;
      blank_d = blank_q;
      case (state_q)
         S_IDLE: begin
            if (i_enable) begin
               state_d = S_VSYNC;
               blank_d = '0;
            end
         end
         S_VSYNC: begin
            if (blank_q == VSYNC_LAST) begin
               state_d = S_VBACK;
               blank_d = '0;
            end else begin
               blank_d = blank_q + KCW'(1);
            end
         end
         S_VBACK: begin
            if (blank_q == VBACK_LAST) begin
               state_d = S_ACTIVE;
               blank_d = '0;
               byte_d  = '0;
               pix_d   = '0;
               line_d  = '0;
            end else begin
               blank_d = blank_q + KCW'(1);
            end
         end
         S_ACTIVE: begin
            if (byte_q == BYTE_LAST) begin
               byte_d = '0;
               if (pix_q == PIX_LAST) begin
                  pix_d   = '0;
                  blank_d = '0;
                  state_d = S_HBLANK;
               end else begin
                  pix_d = pix_q + PCW'(1);
               end
            end else begin
               byte_d = byte_q + BCW'(1);
            end
         end
         S_HBLANK: begin
            if (blank_q == HBLANK_LAST) begin
               blank_d = '0;
               if (line_q == LINE_LAST) begin
                  line_d  = '0;
                  state_d = i_enable ? S_VSYNC : S_IDLE;
               end else begin
                  line_d  = line_q + LCW'(1);
                  state_d = S_ACTIVE;
               end
            end else begin
               blank_d = blank_q + KCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            byte_d  = '0;
            pix_d   = '0;
            line_d  = '0;
            blank_d = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge p_clk or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         byte_q  <= '0;
         pix_q   <= '0;
         line_q  <= '0;
         blank_q <= '0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         blank_q <= blank_d;
      end
   end

   // One-word hold register; an accept in the consume cycle refills it.
   always_ff @(posedge p_clk or negedge RST) begin
      if (!RST) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else if (w_accept) begin
         hold_q      <= pix_if.i_data;
         hold_full_q <= 1'b1;
      end else if (w_consume) begin
         hold_full_q <= 1'b0;
      end
   end

   // Output registers, computed from next state so they line up with state_q.
   always_ff @(posedge p_clk or negedge RST) begin
      if (!RST) begin
         data_q        <= '0;
         shift_q       <= '0;
         h_sync_q      <= 1'b0;
         v_sync_q      <= 1'b0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         v_sync_q      <= (state_d == S_VSYNC);
         h_sync_q      <= (state_d == S_ACTIVE);
         frame_start_q <= (state_d == S_VSYNC) && (state_q != S_VSYNC);
         if (state_d == S_ACTIVE) begin
            if (w_slot_start) begin
               data_q  <= w_pix_word[7:0];
               shift_q <= w_pix_word >> 8;
            end else begin
               data_q  <= shift_q[7:0];
               shift_q <= shift_q >> 8;
            end
         end else begin
            data_q  <= '0;
            shift_q <= '0;
         end
         if (state_q == S_IDLE) begin
            underflow_q <= 1'b0;
         end else if (w_slot_start && !hold_full_q && !w_pattern) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign o_data        = data_q;
   assign h_sync        = h_sync_q;
   assign v_sync        = v_sync_q;
   assign o_frame_start = frame_start_q;
   assign o_underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_byte_tx
// Description : Scoreboard bench for vga_byte_tx (PW=16, 4 px x 2 lines).
//               Expected bytes are queued as stimulus is issued; a monitor
//               pops and compares whenever h_sync is high.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_byte_tx;
   localparam int PW = 16;

   logic       p_clk = 1'b0;
   logic       RST = 1'b0;
   logic       i_enable = 1'b0;
`ifdef TX_TEST_PATTERN_EN
   logic       i_pattern_sel = 1'b0;
`endif
   logic [7:0] o_data;
   logic       h_sync, v_sync, o_frame_start, o_underflow;

   vga_byte_tx_if #(.PixelBitWidth(PW)) pif ();

   vga_byte_tx #(
      .PixelBitWidth(PW), .H_PIXELS(4), .H_BLANK(3), .V_LINES(2),
      .VSYNC_CYCLES(2), .V_BACK_CYCLES(2)
   ) dut (
      .p_clk         (p_clk),
      .RST           (RST),
      .i_enable      (i_enable),
`ifdef TX_TEST_PATTERN_EN
      .i_pattern_sel (i_pattern_sel),
`endif
      .pix_if        (pif.slave),
      .o_data        (o_data),
      .h_sync        (h_sync),
      .v_sync        (v_sync),
      .o_frame_start (o_frame_start),
      .o_underflow   (o_underflow)
   );

   always #5 p_clk = ~p_clk;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, cyc = 0;
   int         fs_cyc = 0, rise_prev = 0, rise_last = 0;
   logic       prev_hs = 1'b0;
   int         drv_mode = 0;   // 0: valid low, 1: valid high, 2: valid with gaps
   int         widx = 0;
   int         gcnt = 0;

   function automatic logic [15:0] word_of(input int k);
      logic [7:0] lo, hi;
      lo = 8'(2 * k + 1);
      hi = 8'(2 * k + 2);
      return {hi, lo};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push_seq(input int first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(8'(first + i));
   endtask

   task automatic wait_bytes(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge p_clk); #1;
         n++;
      end
      if (hs_cnt < target) begin
         checks++; failures++;
         $display("FAIL %s timeout: bytes seen %0d, required %0d", name, hs_cnt, target);
      end
   endtask

   task automatic wait_fs(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (fs_cnt < target && n < budget) begin
         @(negedge p_clk); #1;
         n++;
      end
      if (fs_cnt < target) begin
         checks++; failures++;
         $display("FAIL %s timeout: frame_start pulses %0d, required %0d", name, fs_cnt, target);
      end
   endtask

   task automatic do_reset();
      @(negedge p_clk); #1;
      RST = 1'b0; i_enable = 1'b0; drv_mode = 0;
      repeat (3) @(negedge p_clk);
      #1;
      widx = 0;
      @(negedge p_clk); #1;
      RST = 1'b1;
      @(negedge p_clk); #1;
   endtask

   // Driver: sample the handshake at negedge, advance the word on acceptance.
   initial begin
      logic acc;
      pif.i_valid = 1'b0;
      pif.i_data  = '0;
      forever begin
         @(negedge p_clk);
         acc = RST && pif.i_valid && pif.o_ready;
         @(posedge p_clk); #1;
         if (acc && RST) widx++;
         gcnt++;
         case (drv_mode)
            0:       pif.i_valid = 1'b0;
            1:       pif.i_valid = 1'b1;
            default: pif.i_valid = ((gcnt % 3) != 2);
         endcase
         pif.i_data = word_of(widx);
      end
   end

   // Monitor: pop and compare on every h_sync byte; idle lane must be zero.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge p_clk);
         cyc++;
         if (o_frame_start) begin fs_cnt++; fs_cyc = cyc; end
         if (v_sync) vs_cnt++;
         if (h_sync && !prev_hs) begin rise_prev = rise_last; rise_last = cyc; end
         prev_hs = h_sync;
         checks++;
         if (h_sync) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL byte: got 0x%02h with no byte expected", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  failures++;
                  $display("FAIL byte #%0d: got 0x%02h, expected 0x%02h", hs_cnt, o_data, e);
               end
            end
         end else if (o_data !== 8'h00) begin
            failures++;
            $display("FAIL idle_data: got 0x%02h, expected 0x00 while h_sync low", o_data);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int b, f, v;

      // Reset state
      do_reset();
      check("rst_data", int'(o_data), 0);
      check("rst_hsync", int'(h_sync), 0);
      check("rst_vsync", int'(v_sync), 0);
      check("rst_fstart", int'(o_frame_start), 0);
      check("rst_uflow", int'(o_underflow), 0);
      check("rst_ready", int'(pif.o_ready), 1);

      // Scenario 1: continuous valid, two back-to-back frames
      b = hs_cnt; f = fs_cnt; v = vs_cnt;
      push_seq(1, 32);
      drv_mode = 1; i_enable = 1'b1;
      wait_bytes(b + 8, 100, "s1_line1");
      check("s1_fs_to_hsync", rise_last - fs_cyc, 4);
      wait_bytes(b + 16, 100, "s1_line2");
      check("s1_line_gap", rise_last - rise_prev, 11);
      wait_fs(f + 2, 50, "s1_frame2");
      i_enable = 1'b0;
      wait_bytes(b + 32, 200, "s1_frame2_bytes");
      repeat (10) @(negedge p_clk);
      #1;
      check("s1_fstart_cnt", fs_cnt - f, 2);
      check("s1_vsync_cycles", vs_cnt - v, 4);
      check("s1_uflow", int'(o_underflow), 0);
      check("s1_idle_vsync", int'(v_sync), 0);
      check("s1_queue_empty", exp_q.size(), 0);

      // Scenario 2: no pixels for line 1 -> zero bytes and sticky underflow
      do_reset();
      b = hs_cnt;
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
      push_seq(1, 8);
      drv_mode = 0; i_enable = 1'b1;
      wait_fs(fs_cnt + 1, 20, "s2_fs");
      i_enable = 1'b0;
      wait_bytes(b + 8, 100, "s2_line1");
      check("s2_uflow_set", int'(o_underflow), 1);
      drv_mode = 1;
      wait_bytes(b + 16, 100, "s2_line2");
      check("s2_uflow_sticky", int'(o_underflow), 1);
      repeat (8) @(negedge p_clk);
      #1;
      check("s2_uflow_idle_clear", int'(o_underflow), 0);
      check("s2_queue_empty", exp_q.size(), 0);

      // Scenario 3: valid with single-cycle gaps -> same stream, no underflow
      do_reset();
      b = hs_cnt;
      push_seq(1, 16);
      drv_mode = 2; i_enable = 1'b1;
      wait_fs(fs_cnt + 1, 20, "s3_fs");
      i_enable = 1'b0;
      wait_bytes(b + 16, 200, "s3_bytes");
      check("s3_uflow", int'(o_underflow), 0);
      check("s3_queue_empty", exp_q.size(), 0);

      // Scenario 4: enable dropped mid line 1 -> frame finishes, then IDLE
      do_reset();
      b = hs_cnt; f = fs_cnt; v = vs_cnt;
      push_seq(1, 16);
      drv_mode = 1; i_enable = 1'b1;
      wait_bytes(b + 3, 100, "s4_midline");
      i_enable = 1'b0;
      wait_bytes(b + 16, 100, "s4_bytes");
      repeat (20) @(negedge p_clk);
      #1;
      check("s4_fstart_cnt", fs_cnt - f, 1);
      check("s4_vsync_cycles", vs_cnt - v, 2);
      check("s4_vsync_low", int'(v_sync), 0);
      check("s4_queue_empty", exp_q.size(), 0);

      // Scenario 5: asynchronous reset during byte 3 of line 1
      do_reset();
      b = hs_cnt;
      push_seq(1, 3);
      drv_mode = 1; i_enable = 1'b1;
      wait_bytes(b + 1, 100, "s5_start");
      repeat (3) @(posedge p_clk);
      #2;
      check("s5_byte3", int'(o_data), 8'h04);
      RST = 1'b0; drv_mode = 0; i_enable = 1'b0;
      #1;
      check("s5_rst_data", int'(o_data), 0);
      check("s5_rst_hsync", int'(h_sync), 0);
      check("s5_rst_ready", int'(pif.o_ready), 1);
      repeat (2) @(negedge p_clk);
      #1;
      widx = 0;
      check("s5_queue_empty", exp_q.size(), 0);
      @(negedge p_clk); #1;
      RST = 1'b1;
      repeat (5) @(negedge p_clk);
      #1;
      check("s5_idle_vsync", int'(v_sync), 0);
      b = hs_cnt;
      push_seq(1, 16);
      drv_mode = 1; i_enable = 1'b1;
      wait_fs(fs_cnt + 1, 20, "s5_restart_fs");
      i_enable = 1'b0;
      wait_bytes(b + 16, 100, "s5_restart_bytes");
      check("s5_restart_queue_empty", exp_q.size(), 0);

`ifdef TX_TEST_PATTERN_EN
      // Scenario 6: test pattern replaces the handshake
      do_reset();
      b = hs_cnt;
      i_pattern_sel = 1'b1;
      for (int l = 0; l < 2; l++)
         for (int p = 0; p < 4; p++) begin
            exp_q.push_back(8'(p));
            exp_q.push_back(8'(p));
         end
      drv_mode = 1; i_enable = 1'b1;
      @(negedge p_clk); #1;
      check("s6_ready_low", int'(pif.o_ready), 0);
      wait_fs(fs_cnt + 1, 20, "s6_fs");
      i_enable = 1'b0;
      wait_bytes(b + 16, 100, "s6_bytes");
      check("s6_uflow", int'(o_underflow), 0);
      check("s6_queue_empty", exp_q.size(), 0);
      i_pattern_sel = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
